// File: rtl/ps2_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_pkg                                                   |
// | Purpose  : Shared PS/2 definitions: transmit FSM state encoding,     |
// |            command byte constants and cycle-count helpers derived    |
// |            from the system clock frequency.                          |
// | Ports    : none (package)                                            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INHIBIT  = 3'd1,
    ST_RTS      = 3'd2,
    ST_XFER     = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAITIDLE = 3'd5,
    ST_DONE     = 3'd6,
    ST_ERR      = 3'd7
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SETLED = 8'hED;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;
  localparam logic [7:0] ACK_BYTE   = 8'hFA;

  // 100 us clock inhibit
  function automatic int inhibit_cycles(input int masterclk);
    return masterclk / 10000;
  endfunction

  // 5 us data-low setup before the clock is released
  function automatic int rts_cycles(input int masterclk);
    return masterclk / 200000;
  endfunction

  // ~15 ms whole-transaction watchdog
  function automatic int timeout_cycles(input int masterclk);
    return masterclk / 66;
  endfunction

  // 2 ms maximum gap between device clock edges
  function automatic int edge_to_cycles(input int masterclk);
    return masterclk / 500;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_host_tx_if                                            |
// | Purpose  : Bundle of core handshake and PS/2 line signals for the    |
// |            host-to-device transmitter.                               |
// | Ports    : data/send (core command), busy/done/error (status),       |
// |            ps2clk_in/ps2data_in (raw line levels),                   |
// |            ps2clk_oe/ps2data_oe (pull-low enables).                  |
// |            slave = transmitter side, master = core/board side.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface ps2_host_tx_if;
  logic [7:0] data;
  logic       send;
  logic       busy;
  logic       done;
  logic       error;
  logic       ps2clk_in;
  logic       ps2data_in;
  logic       ps2clk_oe;
  logic       ps2data_oe;

  modport slave (
    input  data, send, ps2clk_in, ps2data_in,
    output busy, done, error, ps2clk_oe, ps2data_oe
  );

  modport master (
    output data, send, ps2clk_in, ps2data_in,
    input  busy, done, error, ps2clk_oe, ps2data_oe
  );
endinterface
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_line_filter                                           |
// | Purpose  : 2-FF synchroniser plus glitch filter for a PS/2 line; the |
// |            filtered level follows the line only after FILTER equal   |
// |            consecutive samples. fall pulses for one cycle on a       |
// |            filtered 1->0 transition.                                 |
// | Ports    : clk, rst (async, active high), line_in (raw level),       |
// |            level (filtered level), fall (one-cycle pulse).           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ps2_line_filter #(
  parameter int   FILTER     = 8,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  localparam int FCW = $clog2(FILTER) + 1;

  logic           r_meta;
  logic           r_sync;
  logic           r_level;
  logic           r_fall;
  logic [FCW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta  <= IDLE_LEVEL;
      r_sync  <= IDLE_LEVEL;
      r_level <= IDLE_LEVEL;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_meta <= line_in;
      r_sync <= r_meta;
      r_fall <= 1'b0;
      if (r_sync == r_level) begin
        // Any sample agreeing with the current level restarts the run.
        r_cnt <= '0;
      end else if (r_cnt == FCW'(FILTER - 1)) begin
        r_level <= r_sync;
        r_cnt   <= '0;
        r_fall  <= r_level;  // level was 1 and is about to become 0
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign fall  = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ps2_host_tx                                               |
// | Purpose  : PS/2 host-to-device transmitter. Inhibits the clock,      |
// |            requests to send, shifts out start/d0..d7/odd parity/stop |
// |            on device clock falls and checks the device ack, with     |
// |            edge-gap and whole-transaction watchdogs.                 |
// | Ports    : clk, rst (async, active high),                            |
// |            bus (ps2_host_tx_if.slave): data/send in, busy/done/error |
// |            out, raw line levels in, pull-low enables out.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int MASTERCLK   = 28000000,
  parameter int INHIBIT_CYC = inhibit_cycles(MASTERCLK),
  parameter int RTS_CYC     = rts_cycles(MASTERCLK),
  parameter int TIMEOUT_CYC = timeout_cycles(MASTERCLK),
  parameter int EDGE_TO_CYC = edge_to_cycles(MASTERCLK),
  parameter int FILTER      = 8
) (
  input  logic          clk,
  input  logic          rst,
  ps2_host_tx_if.slave  bus
);

  localparam int MAX_CYC = max3(INHIBIT_CYC, TIMEOUT_CYC, EDGE_TO_CYC);
  localparam int CW      = $clog2(MAX_CYC + 1);

  ps2_tx_state_t r_state;
  logic [7:0]    r_shreg;
  logic          r_parity;
  logic [3:0]    r_bitcnt;
  logic [CW-1:0] r_cnt;    // inhibit/RTS timer, then edge-gap watchdog
  logic [CW-1:0] r_tcnt;   // transaction watchdog, runs from send accept
  logic          r_clk_oe;
  logic          r_data_oe;
  logic          r_busy;
  logic          r_done;
  logic          r_error;
  logic          r_dmeta;
  logic          r_dsync;

  logic          w_clk_level;
  logic          w_fall;
  logic          w_watch;
  logic          w_expire;

  ps2_line_filter #(
    .FILTER     (FILTER),
    .IDLE_LEVEL (1'b1)
  ) u_clk_filter (
    .clk     (clk),
    .rst     (rst),
    .line_in (bus.ps2clk_in),
    .level   (w_clk_level),
    .fall    (w_fall)
  );

  // Data is only synchronised; it is sampled on filtered clock events.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dmeta <= 1'b1;
      r_dsync <= 1'b1;
    end else begin
      r_dmeta <= bus.ps2data_in;
      r_dsync <= r_dmeta;
    end
  end

  assign w_watch  = (r_state == ST_XFER) || (r_state == ST_ACK) ||
                    (r_state == ST_WAITIDLE);
  // Both watchdogs share one exit, so simultaneous expiry gives one pulse.
  assign w_expire = w_watch && ((r_cnt  >= CW'(EDGE_TO_CYC - 1)) ||
                                (r_tcnt >= CW'(TIMEOUT_CYC - 1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_parity  <= 1'b0;
      r_bitcnt  <= '0;
      r_cnt     <= '0;
      r_tcnt    <= '0;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      if (r_state != ST_IDLE) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      // The watchdog takes priority over a fall arriving in the same cycle.
      if (w_expire) begin
        r_state   <= ST_ERR;
        r_clk_oe  <= 1'b0;
        r_data_oe <= 1'b0;
        r_error   <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
            if (bus.send) begin
              r_shreg  <= bus.data;
              r_parity <= ~^bus.data;
              r_busy   <= 1'b1;
              r_cnt    <= '0;
              r_tcnt   <= '0;
              r_clk_oe <= 1'b1;
              r_state  <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (r_cnt == CW'(INHIBIT_CYC - 1)) begin
              r_cnt     <= '0;
              r_data_oe <= 1'b1;  // start bit
              r_state   <= ST_RTS;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_RTS: begin
            if (r_cnt == CW'(RTS_CYC - 1)) begin
              r_cnt    <= '0;
              r_bitcnt <= '0;
              r_clk_oe <= 1'b0;
              r_state  <= ST_XFER;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_XFER: begin
            if (w_fall) begin
              r_cnt    <= '0;
              r_bitcnt <= r_bitcnt + 1'b1;
              // r_bitcnt holds the number of falls seen before this one.
              if (r_bitcnt < 4'd8) begin
                r_data_oe <= ~r_shreg[0];
                r_shreg   <= {1'b0, r_shreg[7:1]};
              end else if (r_bitcnt == 4'd8) begin
                r_data_oe <= ~r_parity;
              end else begin
                r_data_oe <= 1'b0;  // stop bit: release the line
                r_state   <= ST_ACK;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_ACK: begin
            if (w_fall) begin
              r_cnt <= '0;
              if (!r_dsync) begin
                r_state <= ST_WAITIDLE;
              end else begin
                r_error <= 1'b1;
                r_state <= ST_ERR;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_WAITIDLE: begin
            r_cnt <= r_cnt + 1'b1;
            if (w_clk_level && r_dsync) begin
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
          ST_DONE: begin
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
          default: begin  // ST_ERR
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
            r_error   <= 1'b0;
            r_busy    <= 1'b0;
            r_state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.ps2clk_oe  = r_clk_oe;
  assign bus.ps2data_oe = r_data_oe;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
Name:
ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends command bytes from the core to the keyboard or mouse, such as LED set (0xED), reset (0xFF) and mouse stream enable (0xF4).
- It is the other direction of the existing device-to-host PS/2 receive path on clkps2/dataps2 and mouseclk/mousedata.
- It drives the open-drain lines through pull-low enables. The top level resolves them as assign line = oe ? 1'b0 : 1'bz.
- While busy is high, the existing PS/2 receiver must ignore the bus.

Parameters:
- MASTERCLK, 28000000: clk frequency in Hz.
- INHIBIT_CYC, MASTERCLK/10000: clock-inhibit length, 100 us.
- RTS_CYC, MASTERCLK/200000: data-low setup time before releasing clock, 5 us.
- TIMEOUT_CYC, MASTERCLK/66: whole-transaction watchdog, ~15 ms.
- EDGE_TO_CYC, MASTERCLK/500: maximum gap between device clock edges, 2 ms.
- FILTER, 8: number of consecutive equal samples required to accept a new ps2clk level.

Ports:
- clk  in  1  system clock (sysclk domain).
- rst  in  1  asynchronous, active-high reset.
- ps2clk_in  in  1  raw PS/2 clock line level.
- ps2data_in  in  1  raw PS/2 data line level.
- ps2clk_oe  out  1  1 = pull the clock line low.
- ps2data_oe  out  1  1 = pull the data line low.
- data  in  8  command byte, captured on send.
- send  in  1  one-cycle start strobe.
- busy  out  1  high from the send accept through DONE/ERR.
- done  out  1  one-cycle pulse on acknowledged success.
- error  out  1  one-cycle pulse on timeout or missing ack.

Behaviour:
- Reset values:
  - Outputs: ps2clk_oe=0, ps2data_oe=0, busy=0, done=0, error=0.
  - Internal: state=IDLE, filtered clock=1.
- Reset asserted mid-transaction releases both lines immediately, with no cleanup.
- Input conditioning:
  - Each input goes through a 2-FF synchroniser.
  - ps2clk is then filtered: the filtered level changes only after FILTER identical consecutive samples.
  - fall = filtered 1 to 0 transition, a one-cycle pulse.
  - Data is sampled from the synchronised (unfiltered) line.
- Frame, sent LSB first: start 0, d0..d7, odd parity (~^data), stop 1, then device ack 0.
- State machine:
  - IDLE: send=1 latches data into shreg, computes parity, sets busy=1 and goes to INHIBIT. Any send outside IDLE is ignored.
  - INHIBIT: ps2clk_oe=1 for INHIBIT_CYC cycles, then RTS.
  - RTS: ps2data_oe=1 (start bit), ps2clk_oe still 1 for RTS_CYC cycles. Then release the clock (ps2clk_oe=0), clear bitcnt and go to XFER.
  - XFER: on each fall, bitcnt increments and data is changed while the clock is low.
    - Falls 1-8: ps2data_oe = ~shreg[0], then shift right.
    - Fall 9: ps2data_oe = ~parity.
    - Fall 10: ps2data_oe=0 (stop bit, line released); go to ACK.
  - ACK: at the next fall, sample data. 0 goes to WAITIDLE; 1 goes to ERR.
  - WAITIDLE: wait until filtered clock=1 and data=1, then DONE.
  - DONE: done=1 for one cycle, busy=0 on the following cycle, back to IDLE.
  - ERR: release both lines, error=1 for one cycle, busy=0, back to IDLE.
- Watchdogs, active only in XFER, ACK and WAITIDLE:
  - The edge counter resets on every fall; reaching EDGE_TO_CYC goes to ERR.
  - The transaction counter starts at the send accept; reaching TIMEOUT_CYC goes to ERR.
  - If both expire in the same cycle, a single error pulse is issued.
- A device that never clocks after RTS produces ERR after EDGE_TO_CYC. ps2data_oe stays asserted until then.
- A fall arriving in the same cycle as a watchdog expiry: the watchdog wins.
- done and error are mutually exclusive. busy is high in every non-IDLE state.
- Counter widths are $clog2 of the largest cycle constant: 19 bits at 28 MHz for TIMEOUT_CYC=424242.

Decomposition:
- Shared package, ps2_pkg (also usable by the receiver):
  - State encoding constants.
  - Command constants: CMD_SETLED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, ACK_BYTE=8'hFA.
  - Cycle-count localparam helper functions taking MASTERCLK.
- Sub-module ps2_line_filter: 2-FF sync plus the FILTER glitch filter and fall detection. Instantiate it once for ps2clk and reuse it in the receiver.
- The FSM, shift register and counters stay in ps2_host_tx.

Test Plan:
- Send 8'hED with the device model clocking at 12.5 kHz and acking.
  - Clock is held low ≥ INHIBIT_CYC (2800 cycles).
  - Data bits seen on rising edges: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - One done pulse, error stays 0, busy falls the cycle after done.
- Send 8'h07: parity bit 0. Send 8'hFF: parity bit 1. Send 8'h00: parity bit 1. All three complete with done.
- Device holds data=1 at the ack fall: error pulses once, no done, both oe=0, state back to IDLE.
- Device never clocks after RTS: error after EDGE_TO_CYC (56000) cycles ±2, ps2data_oe released.
- Inject 3-cycle glitches on ps2clk during XFER: bitcnt does not advance and the frame is still correct.
- Assert rst during XFER bit 4: oe outputs go to 0 asynchronously in the same cycle. A new send of 8'hF4 after reset completes normally. A send pulsed while busy is ignored (no second frame).
